// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz VGA timing constants. The sync generator takes its
// defaults from here, and the renderers use it for their region bounds.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] coord_t;

  localparam int CLK_DIV_DEF   = 4;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Sync pulse windows, inclusive on both ends.
  localparam int H_SYNC_START = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int V_SYNC_START = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // True when a counter value lies inside the inclusive window [lo, hi].
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the renderers and the output stage.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_tick;
  coord_t x;
  coord_t y;

  modport master (
    output hsync, vsync, video_on, p_tick, frame_tick, x, y
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, frame_tick, x, y
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Mod-CLK_DIV counter producing a one-clock pixel tick every CLK_DIV clocks.
// With CLK_DIV = 1 the counter sits at 0 and the tick is held high.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next divider value: wrap after the last count.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  // Divider register; reset restarts a full pixel period.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel tick, h/v counters, registered active-low syncs,
// video_on and a frame tick on the pixel that wraps both counters.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam coord_t X_LAST = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOT - 1);
  localparam coord_t X_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t Y_VIS  = coord_t'(V_DISPLAY);

  logic   p_tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hsync_q, vsync_q;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_div (
    .clk      (clk),
    .reset    (reset),
    .p_tick_o (p_tick)
  );

  // Next counter values: x advances per pixel tick, y advances as x wraps.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Counters and syncs; syncs decode the next counter values so they line up with x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= !in_window(x_d, HS_START, HS_END);
      vsync_q <= !in_window(y_d, VS_START, VS_END);
    end
  end

  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.p_tick     = p_tick;
  assign vga.video_on   = (x_q < X_VIS) && (y_q < Y_VIS);
  assign vga.frame_tick = p_tick && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, CLK_DIV = 1, and a
// shrunken geometry so whole frames fit in a short run), each compared every
// cycle against a closed-form model driven by cycles elapsed since reset.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int checks = 0;
  int errors = 0;

  vga_sync_gen_if if_a ();
  vga_sync_gen_if if_b ();
  vga_sync_gen_if if_c ();

  vga_sync_gen dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (if_a)
  );

  vga_sync_gen #(
    .CLK_DIV (1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (if_b)
  );

  // Small geometry: H_TOTAL = 15 (hsync at x 10..12), V_TOTAL = 10 (vsync at y 7..8).
  vga_sync_gen #(
    .CLK_DIV   (2),
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (2),
    .V_DISPLAY (6),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1)
  ) dut_c (
    .clk   (clk),
    .reset (rst_c),
    .vga   (if_c)
  );

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {if_a.hsync, if_a.vsync, if_a.video_on, if_a.p_tick, if_a.frame_tick, if_a.x, if_a.y};
  assign obs_b = {if_b.hsync, if_b.vsync, if_b.video_on, if_b.p_tick, if_b.frame_tick, if_b.x, if_b.y};
  assign obs_c = {if_c.hsync, if_c.vsync, if_c.video_on, if_c.p_tick, if_c.frame_tick, if_c.x, if_c.y};

  // Outputs as a function of clocks elapsed since reset: pixel index t/cd,
  // then column and line by division over the line and frame lengths.
  function automatic obs_t model(int t, int cd, int hd, int hf, int hs, int hb,
                                 int vd, int vf, int vs, int vb);
    obs_t m;
    int ht = hd + hf + hs + hb;
    int vt = vd + vf + vs + vb;
    int p  = t / cd;
    int xx = p % ht;
    int yy = (p / ht) % vt;
    m.x   = 10'(xx);
    m.y   = 10'(yy);
    m.pt  = ((t % cd) == cd - 1);
    m.hs  = !((xx >= hd + hf) && (xx < hd + hf + hs));
    m.vs  = !((yy >= vd + vf) && (yy < vd + vf + vs));
    m.von = (xx < hd) && (yy < vd);
    m.ft  = m.pt && (xx == ht - 1) && (yy == vt - 1);
    return m;
  endfunction

  int ta = 0, tb = 0, tc = 0;
  bit va = 0, vb = 0, vc = 0;

  always @(posedge clk) begin
    if (rst_a) begin ta <= 0; va <= 1'b1; end else ta <= ta + 1;
    if (rst_b) begin tb <= 0; vb <= 1'b1; end else tb <= tb + 1;
    if (rst_c) begin tc <= 0; vc <= 1'b1; end else tc <= tc + 1;
  end

  task automatic cmp(string name, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got hs=%b vs=%b von=%b pt=%b ft=%b x=%0d y=%0d, want hs=%b vs=%b von=%b pt=%b ft=%b x=%0d y=%0d",
               name, $time, act.hs, act.vs, act.von, act.pt, act.ft, act.x, act.y,
               exp.hs, exp.vs, exp.von, exp.pt, exp.ft, exp.x, exp.y);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (va) cmp("cyc_a", obs_a, model(ta, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    if (vb) cmp("cyc_b", obs_b, model(tb, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    if (vc) cmp("cyc_c", obs_c, model(tc, 2, 8, 2, 3, 2, 6, 1, 2, 1));
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_a(int xv, int yv, string name);
    int n = 0;
    while (!(int'(if_a.x) == xv && int'(if_a.y) == yv) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s: timeout waiting for x=%0d y=%0d, got x=%0d y=%0d", name, xv, yv, if_a.x, if_a.y);
    end
  endtask

  task automatic wait_c(int xv, int yv, string name);
    int n = 0;
    while (!(int'(if_c.x) == xv && int'(if_c.y) == yv) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL %s: timeout waiting for x=%0d y=%0d, got x=%0d y=%0d", name, xv, yv, if_c.x, if_c.y);
    end
  endtask

  task automatic reset_vals_a(string tag);
    chk({tag, "_x"}, int'(if_a.x), 0);
    chk({tag, "_y"}, int'(if_a.y), 0);
    chk({tag, "_hs"}, int'(if_a.hsync), 1);
    chk({tag, "_vs"}, int'(if_a.vsync), 1);
    chk({tag, "_pt"}, int'(if_a.p_tick), 0);
    chk({tag, "_ft"}, int'(if_a.frame_tick), 0);
    chk({tag, "_von"}, int'(if_a.video_on), 1);
  endtask

  // After release: tick on the 4th clock (3rd falling edge), x = 1 after it.
  task automatic release_a(string tag);
    @(negedge clk); chk({tag, "_pt1"}, int'(if_a.p_tick), 0);
    @(negedge clk); chk({tag, "_pt2"}, int'(if_a.p_tick), 0);
    @(negedge clk); chk({tag, "_pt3"}, int'(if_a.p_tick), 1);
                    chk({tag, "_x3"}, int'(if_a.x), 0);
    @(negedge clk); chk({tag, "_x4"}, int'(if_a.x), 1);
                    chk({tag, "_pt4"}, int'(if_a.p_tick), 0);
  endtask

  task automatic seq_a();
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    reset_vals_a("a_rst");
    rst_a = 1'b0;
    release_a("a_rel");
    wait_a(639, 0, "a_w639"); chk("a_von639", int'(if_a.video_on), 1);
    wait_a(640, 0, "a_w640"); chk("a_von640", int'(if_a.video_on), 0);
    wait_a(655, 0, "a_w655"); chk("a_hs655", int'(if_a.hsync), 1);
    wait_a(656, 0, "a_w656"); chk("a_hs656", int'(if_a.hsync), 0);
    wait_a(751, 0, "a_w751"); chk("a_hs751", int'(if_a.hsync), 0);
    wait_a(752, 0, "a_w752"); chk("a_hs752", int'(if_a.hsync), 1);
    wait_a(799, 0, "a_w799"); chk("a_von799", int'(if_a.video_on), 0);
    wait_a(0, 1, "a_wrap");   chk("a_wrap_von", int'(if_a.video_on), 1);
                              chk("a_wrap_ft", int'(if_a.frame_tick), 0);
    wait_a(300, 1, "a_w300");
    rst_a = 1'b1;
    @(negedge clk);
    reset_vals_a("a_mid");
    rst_a = 1'b0;
    release_a("a_rel2");
    repeat (40) @(negedge clk);
  endtask

  task automatic seq_b();
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("b_rst_pt", int'(if_b.p_tick), 1);
    chk("b_rst_x", int'(if_b.x), 0);
    rst_b = 1'b0;
    @(negedge clk);
    chk("b_x1", int'(if_b.x), 1);
    repeat (799) @(negedge clk);
    chk("b_line_x", int'(if_b.x), 0);
    chk("b_line_y", int'(if_b.y), 1);
    chk("b_line_pt", int'(if_b.p_tick), 1);
  endtask

  task automatic seq_c();
    int ft_n = 0;
    int vs_n = 0;
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    // First frame: 15 * 10 * 2 = 300 clocks, exactly one frame tick at (14, 9).
    repeat (300) begin
      @(negedge clk);
      if (if_c.frame_tick) begin
        ft_n++;
        chk("c_ft_x", int'(if_c.x), 14);
        chk("c_ft_y", int'(if_c.y), 9);
      end
    end
    chk("c_ft_count", ft_n, 1);
    chk("c_wrap_x", int'(if_c.x), 0);
    chk("c_wrap_y", int'(if_c.y), 0);
    // Second frame: vsync low for two lines = 2 * 15 * 2 = 60 clocks.
    ft_n = 0;
    repeat (300) begin
      @(negedge clk);
      if (!if_c.vsync) vs_n++;
      if (if_c.frame_tick) ft_n++;
    end
    chk("c_vs_low", vs_n, 60);
    chk("c_ft_count2", ft_n, 1);
    wait_c(5, 4, "c_w54");
    rst_c = 1'b1;
    @(negedge clk);
    chk("c_mid_x", int'(if_c.x), 0);
    chk("c_mid_y", int'(if_c.y), 0);
    chk("c_mid_vs", int'(if_c.vsync), 1);
    rst_c = 1'b0;
    @(negedge clk);
    chk("c_rel_pt", int'(if_c.p_tick), 1);
    @(negedge clk);
    chk("c_rel_x", int'(if_c.x), 1);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
      seq_c();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
